// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Includes the FSM state encoding, the forwarding select codes and the register match helper.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } fsm_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int REG_W = 5;

  // r0 is hardwired to zero, so a write to it can never feed a consumer.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dest,
                                     input logic             wb_en);
    return wb_en && (src != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-facing bundle of the hazard/forwarding controller.
// Handshake: mem_req is held high by MEM while an access is pending; the access completes on the edge where mem_ready is high.
interface hazard_fwd_ctrl_if;
  logic [4:0]  src1_ID;
  logic [4:0]  src2_ID;
  logic        is_imm_ID;
  logic [4:0]  dest_EXE;
  logic        WB_en_EXE;
  logic        mem_read_EXE;
  logic [4:0]  dest_MEM;
  logic        WB_en_MEM;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        hazard_stall;
  logic        flush;
  logic        freeze;
  logic [1:0]  ALU_vONE_Mux;
  logic [1:0]  ALU_vTWO_Mux;
  logic [1:0]  SRC_vTWO_Mux;
  logic [15:0] stall_cycles;
  logic [1:0]  fsm_state;

  modport master (
    output src1_ID, src2_ID, is_imm_ID, dest_EXE, WB_en_EXE, mem_read_EXE,
           dest_MEM, WB_en_MEM, br_taken, mem_req, mem_ready,
    input  hazard_stall, flush, freeze, ALU_vONE_Mux, ALU_vTWO_Mux,
           SRC_vTWO_Mux, stall_cycles, fsm_state
  );

  modport slave (
    input  src1_ID, src2_ID, is_imm_ID, dest_EXE, WB_en_EXE, mem_read_EXE,
           dest_MEM, WB_en_MEM, br_taken, mem_req, mem_ready,
    output hazard_stall, flush, freeze, ALU_vONE_Mux, ALU_vTWO_Mux,
           SRC_vTWO_Mux, stall_cycles, fsm_state
  );
endinterface

// File: rtl/hazard_fwd_match.sv
// Compares one source register against the EXE and MEM destinations.
// Produces the match flags and the forwarding select, with EXE taking priority over MEM.
module hazard_fwd_match
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic             en,
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] dest_EXE,
  input  logic             WB_en_EXE,
  input  logic [REG_W-1:0] dest_MEM,
  input  logic             WB_en_MEM,
  output logic             match_exe,
  output logic             match_mem,
  output logic [1:0]       sel
);

  assign match_exe = en & reg_match(src, dest_EXE, WB_en_EXE);
  assign match_mem = en & reg_match(src, dest_MEM, WB_en_MEM);

  always_comb begin
    sel = FWD_REG;
    if (match_exe)      sel = FWD_ALU;
    else if (match_mem) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller: freeze/flush/stall generation, stall FSM and registered forwarding selects.
// Forwarding is built only with HAZARD_FORWARDING_EN; otherwise every RAW dependency stalls until it clears.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  hazard_fwd_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_LD_STALL = LD_STALL;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] stall_cnt;
  logic        freeze;
  logic        flush;
  logic        raw_hazard;
  logic        hazard_stall;

  logic        m1_exe, m1_mem, m2_exe, m2_mem, m3_exe, m3_mem;
  logic [1:0]  sel1, sel2_alu, sel2_src;

  // src2 as ALU operand is irrelevant for immediate instructions.
  hazard_fwd_match u_match_alu1 (
    .en(1'b1), .src(bus.src1_ID),
    .dest_EXE(bus.dest_EXE), .WB_en_EXE(bus.WB_en_EXE),
    .dest_MEM(bus.dest_MEM), .WB_en_MEM(bus.WB_en_MEM),
    .match_exe(m1_exe), .match_mem(m1_mem), .sel(sel1)
  );

  hazard_fwd_match u_match_alu2 (
    .en(~bus.is_imm_ID), .src(bus.src2_ID),
    .dest_EXE(bus.dest_EXE), .WB_en_EXE(bus.WB_en_EXE),
    .dest_MEM(bus.dest_MEM), .WB_en_MEM(bus.WB_en_MEM),
    .match_exe(m2_exe), .match_mem(m2_mem), .sel(sel2_alu)
  );

  hazard_fwd_match u_match_src2 (
    .en(1'b1), .src(bus.src2_ID),
    .dest_EXE(bus.dest_EXE), .WB_en_EXE(bus.WB_en_EXE),
    .dest_MEM(bus.dest_MEM), .WB_en_MEM(bus.WB_en_MEM),
    .match_exe(m3_exe), .match_mem(m3_mem), .sel(sel2_src)
  );

  assign freeze       = (bus.mem_req & ~bus.mem_ready) |
                        ((state == S_MEM_WAIT) & ~bus.mem_ready);
  assign flush        = bus.br_taken & ~freeze;
  assign hazard_stall = raw_hazard & ~freeze & ~bus.br_taken;

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] alu1_q, alu2_q, src2_q;
  logic       unused_flags;

  // Only a load still in EXE cannot be forwarded; its bubble resolves it in one cycle.
  assign raw_hazard = bus.mem_read_EXE & (m1_exe | m2_exe);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu1_q <= FWD_REG;
      alu2_q <= FWD_REG;
      src2_q <= FWD_REG;
    end else if (!freeze) begin
      if (flush | hazard_stall) begin
        alu1_q <= FWD_REG;
        alu2_q <= FWD_REG;
        src2_q <= FWD_REG;
      end else begin
        alu1_q <= sel1;
        alu2_q <= sel2_alu;
        src2_q <= sel2_src;
      end
    end
  end

  assign bus.ALU_vONE_Mux = alu1_q;
  assign bus.ALU_vTWO_Mux = alu2_q;
  assign bus.SRC_vTWO_Mux = src2_q;
  assign unused_flags     = &{1'b0, m1_mem, m2_mem, m3_exe, m3_mem};
`else
  logic unused_flags;

  assign raw_hazard       = m1_exe | m1_mem | m2_exe | m2_mem;
  assign bus.ALU_vONE_Mux = FWD_REG;
  assign bus.ALU_vTWO_Mux = FWD_REG;
  assign bus.SRC_vTWO_Mux = FWD_REG;
  assign unused_flags     = &{1'b0, m3_exe, m3_mem, sel1, sel2_alu, sel2_src,
                              bus.mem_read_EXE};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (freeze)            state_nxt = S_MEM_WAIT;
        else if (hazard_stall) state_nxt = S_LD_STALL;
        else                   state_nxt = S_RUN;
      end
      S_LD_STALL: begin
        if (freeze)                       state_nxt = S_MEM_WAIT;
        else if (FWD_EN || !hazard_stall) state_nxt = S_RUN;
        else                              state_nxt = S_LD_STALL;
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if ((freeze | hazard_stall) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.freeze       = freeze;
  assign bus.flush        = flush;
  assign bus.hazard_stall = hazard_stall;
  assign bus.stall_cycles = stall_cnt;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; expectations follow HAZARD_FORWARDING_EN when it is defined.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  typedef struct {
    logic [4:0] s1, s2; logic imm;
    logic [4:0] de; logic we, mr;
    logic [4:0] dm; logic wm, br;
  } in_t;

  typedef struct {
    logic stall, flush;
    logic [1:0] st, a1, a2, s2;
  } exp_t;

  localparam int NV = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if bus();
  hazard_fwd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  exp_q[$];

  in_t  vin  [NV];
  exp_t vexp [NV];
  in_t  zero_v, a_v, abr_v;
  logic [1:0] held;

  function automatic in_t mk(input int s1, s2, imm, de, we, mr, dm, wm, br);
    in_t v;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.imm = 1'(imm);
    v.de = 5'(de); v.we = 1'(we); v.mr = 1'(mr);
    v.dm = 5'(dm); v.wm = 1'(wm); v.br = 1'(br);
    return v;
  endfunction

  function automatic exp_t mke(input int stall, flush, st, a1, a2, s2);
    exp_t e;
    e.stall = 1'(stall); e.flush = 1'(flush); e.st = 2'(st);
    e.a1 = 2'(a1); e.a2 = 2'(a2); e.s2 = 2'(s2);
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v, input logic mreq, input logic mrdy);
    bus.src1_ID = v.s1; bus.src2_ID = v.s2; bus.is_imm_ID = v.imm;
    bus.dest_EXE = v.de; bus.WB_en_EXE = v.we; bus.mem_read_EXE = v.mr;
    bus.dest_MEM = v.dm; bus.WB_en_MEM = v.wm; bus.br_taken = v.br;
    bus.mem_req = mreq; bus.mem_ready = mrdy;
  endtask

  // One pipeline cycle: drive at negedge, check combinational outputs, then registered state after the edge.
  task automatic step(input string tag, input in_t v, input logic mreq, input logic mrdy,
                      input logic e_frz, input logic e_flush, input logic e_stall,
                      input logic [1:0] e_st, input logic [1:0] e_a1,
                      input logic [1:0] e_a2, input logic [1:0] e_s2);
    logic [7:0] e;
    @(negedge clk);
    apply(v, mreq, mrdy);
    #1;
    check({tag, ".freeze"}, 16'(bus.freeze), 16'(e_frz));
    check({tag, ".flush"},  16'(bus.flush),  16'(e_flush));
    check({tag, ".stall"},  16'(bus.hazard_stall), 16'(e_stall));
    if ((e_frz | e_stall) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({e_st, e_a1, e_a2, e_s2});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".state"}, 16'(bus.fsm_state), 16'(e[7:6]));
    check({tag, ".alu1"},  16'(bus.ALU_vONE_Mux), 16'(e[5:4]));
    check({tag, ".alu2"},  16'(bus.ALU_vTWO_Mux), 16'(e[3:2]));
    check({tag, ".src2"},  16'(bus.SRC_vTWO_Mux), 16'(e[1:0]));
    check({tag, ".cnt"},   bus.stall_cycles, exp_cnt);
  endtask

  task automatic check_regs_reset(input string tag);
    check({tag, ".state"}, 16'(bus.fsm_state), 16'(RUN));
    check({tag, ".alu1"},  16'(bus.ALU_vONE_Mux), 16'(FWD_REG));
    check({tag, ".alu2"},  16'(bus.ALU_vTWO_Mux), 16'(FWD_REG));
    check({tag, ".src2"},  16'(bus.SRC_vTWO_Mux), 16'(FWD_REG));
    check({tag, ".cnt"},   bus.stall_cycles, 16'd0);
  endtask

  initial begin
    //            s1 s2 im de we mr dm wm br
    vin[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vin[1]  = mk(3, 0, 0, 3, 1, 0, 0, 0, 0);
    vin[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vin[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vin[4]  = mk(7, 0, 0, 0, 0, 0, 7, 1, 0);
    vin[5]  = mk(7, 0, 0, 0, 0, 0, 7, 1, 0);
    vin[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vin[7]  = mk(0, 5, 1, 5, 1, 1, 0, 0, 0);
    vin[8]  = mk(0, 5, 0, 5, 1, 1, 0, 0, 0);
    vin[9]  = mk(0, 5, 0, 0, 0, 0, 5, 1, 0);
    vin[10] = mk(0, 5, 0, 5, 1, 1, 0, 0, 1);
    vin[11] = mk(0, 5, 0, 5, 0, 1, 0, 0, 0);
    vin[12] = mk(9, 0, 0, 9, 1, 0, 9, 1, 0);
    vin[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    //             stall flush state a1 a2 s2
    vexp[0]  = mke(0, 0, 0, 0, 0, 0);
    vexp[1]  = mke(0, 0, 0, 1, 0, 0);
    vexp[2]  = mke(0, 0, 0, 0, 0, 0);
    vexp[3]  = mke(0, 0, 0, 0, 0, 0);
    vexp[4]  = mke(0, 0, 0, 2, 0, 0);
    vexp[5]  = mke(0, 0, 0, 2, 0, 0);
    vexp[6]  = mke(0, 0, 0, 0, 0, 0);
    vexp[7]  = mke(0, 0, 0, 0, 0, 1);
    vexp[8]  = mke(1, 0, 1, 0, 0, 0);
    vexp[9]  = mke(0, 0, 0, 0, 2, 2);
    vexp[10] = mke(0, 1, 0, 0, 0, 0);
    vexp[11] = mke(0, 0, 0, 0, 0, 0);
    vexp[12] = mke(0, 0, 0, 1, 0, 0);
    vexp[13] = mke(0, 0, 0, 0, 0, 0);
`else
    vexp[0]  = mke(0, 0, 0, 0, 0, 0);
    vexp[1]  = mke(1, 0, 1, 0, 0, 0);
    vexp[2]  = mke(0, 0, 0, 0, 0, 0);
    vexp[3]  = mke(0, 0, 0, 0, 0, 0);
    vexp[4]  = mke(1, 0, 1, 0, 0, 0);
    vexp[5]  = mke(1, 0, 1, 0, 0, 0);
    vexp[6]  = mke(0, 0, 0, 0, 0, 0);
    vexp[7]  = mke(0, 0, 0, 0, 0, 0);
    vexp[8]  = mke(1, 0, 1, 0, 0, 0);
    vexp[9]  = mke(1, 0, 1, 0, 0, 0);
    vexp[10] = mke(0, 1, 0, 0, 0, 0);
    vexp[11] = mke(0, 0, 0, 0, 0, 0);
    vexp[12] = mke(1, 0, 1, 0, 0, 0);
    vexp[13] = mke(0, 0, 0, 0, 0, 0);
`endif
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    a_v    = mk(3, 0, 0, 3, 1, 0, 0, 0, 0);
    abr_v  = mk(3, 0, 0, 3, 1, 0, 0, 0, 1);

    // Reset: registers cleared, combinational outputs still follow their equations.
    apply(zero_v, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_regs_reset("rst0");
    bus.br_taken = 1'b1;
    #1;
    check("rst0.flush", 16'(bus.flush), 16'd1);
    bus.br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      step($sformatf("vec%0d", i), vin[i], 1'b0, 1'b0, 1'b0,
           vexp[i].flush, vexp[i].stall, vexp[i].st, vexp[i].a1, vexp[i].a2, vexp[i].s2);

    // Freeze holds selects; a branch held through it flushes once memory completes.
`ifdef HAZARD_FORWARDING_EN
    step("fz_setup", a_v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(RUN), FWD_ALU, FWD_REG, FWD_REG);
    held = FWD_ALU;
`else
    step("fz_setup", a_v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(LD_STALL), FWD_REG, FWD_REG, FWD_REG);
    held = FWD_REG;
`endif
    step("fz1", abr_v, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(MEM_WAIT), held, FWD_REG, FWD_REG);
    step("fz2", abr_v, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(MEM_WAIT), held, FWD_REG, FWD_REG);
    step("fz3", abr_v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(MEM_WAIT), held, FWD_REG, FWD_REG);
    step("fz_rel", abr_v, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'(RUN), FWD_REG, FWD_REG, FWD_REG);
    step("fz_clr", zero_v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(RUN), FWD_REG, FWD_REG, FWD_REG);

    // Reset taken while waiting on memory abandons MEM_WAIT at once.
    step("rw_enter", zero_v, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(MEM_WAIT), FWD_REG, FWD_REG, FWD_REG);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs_reset("rw_rst");
    check("rw_rst.freeze_req", 16'(bus.freeze), 16'd1);
    bus.mem_req = 1'b0;
    #1;
    check("rw_rst.freeze_idle", 16'(bus.freeze), 16'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", zero_v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(RUN), FWD_REG, FWD_REG, FWD_REG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have the ports below, with the clock and reset listed first. It SHALL use one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- src1_ID, src2_ID  in  5 each  source register numbers of the instruction in ID.
- is_imm_ID  in  1  the instruction in ID uses an immediate as ALU operand 2.
- dest_EXE, WB_en_EXE, mem_read_EXE  in  5/1/1  destination, writeback enable and load flag of the instruction in EXE.
- dest_MEM, WB_en_MEM  in  5/1  destination and writeback enable of the instruction in MEM.
- br_taken  in  1  taken-branch flag from the condition check in EXE.
- mem_req, mem_ready  in  1 each  data-memory access pending in MEM; memory done.
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- freeze  out  1  hold every pipeline register.
- ALU_vONE_Mux, ALU_vTWO_Mux, SRC_vTWO_Mux  out  2 each  forwarding selects: 00 register file, 01 EXE/MEM ALU result, 10 WB result; 11 never driven.
- stall_cycles  out  16  saturating count of cycles with freeze or hazard_stall high.

Function
REQ-002 Matches SHALL ignore register 0: a source equal to 0 never matches.
REQ-003 freeze SHALL equal (mem_req & ~mem_ready) | (state==MEM_WAIT & ~mem_ready), combinationally.
REQ-004 flush SHALL equal br_taken & ~freeze, combinationally.
REQ-005 hazard_stall SHALL equal raw_hazard & ~freeze & ~br_taken, where raw_hazard is defined in REQ-014.
- Priority is freeze > flush > stall.
- A branch held during freeze SHALL produce flush in the cycle freeze drops.
REQ-006 The FSM SHALL have the states RUN, LD_STALL and MEM_WAIT.
REQ-007 In RUN, the FSM SHALL go to MEM_WAIT if freeze is high, else to LD_STALL if hazard_stall is high, else stay in RUN.
REQ-008 LD_STALL SHALL return to RUN after exactly one cycle, or go to MEM_WAIT if freeze is high.
REQ-009 MEM_WAIT SHALL stay while mem_ready is low and go to RUN on the edge where mem_ready is high.
REQ-010 The forwarding selects SHALL be registered and computed in ID for the next EXE cycle. They SHALL be updated on each edge where freeze is low and SHALL hold while freeze is high.
REQ-011 When flush or hazard_stall is high, all three selects SHALL be loaded with 00 (bubble).
REQ-012 Otherwise, for each source s, the select SHALL be:
- 01 if WB_en_EXE & dest_EXE==s;
- else 10 if WB_en_MEM & dest_MEM==s;
- else 00.
- The 01 condition has priority over 10.
REQ-013 The selects SHALL be driven from the following sources:
- ALU_vONE_Mux from src1_ID;
- SRC_vTWO_Mux from src2_ID;
- ALU_vTWO_Mux from src2_ID, forced to 00 when is_imm_ID is high.
REQ-014 raw_hazard SHALL be defined as follows:
- Per source s, excluding src2 when is_imm_ID is high.
- Load-use: mem_read_EXE & WB_en_EXE & dest_EXE matches a used source.
- With forwarding compiled in, raw_hazard is load-use only; it lasts one cycle because the bubble then occupies EXE.
REQ-015 stall_cycles SHALL increment by 1 on each edge with freeze | hazard_stall and SHALL saturate at 16'hFFFF.

Reset
REQ-016 While rst is low, the block SHALL drive:
- state = RUN;
- all selects = 00;
- stall_cycles = 0.
REQ-017 The combinational outputs SHALL follow their equations during reset; the pipeline registers themselves are reset separately.
REQ-018 A reset asserted during MEM_WAIT or LD_STALL SHALL abandon that state immediately.

Configuration
REQ-019 The feature SHALL be controlled by macro HAZARD_FORWARDING_EN.
REQ-020 With HAZARD_FORWARDING_EN defined, behaviour SHALL be as in REQ-010 to REQ-014.
REQ-021 Without HAZARD_FORWARDING_EN:
- all select outputs SHALL be constant 00;
- raw_hazard SHALL be any used source matching dest_EXE with WB_en_EXE, or dest_MEM with WB_en_MEM;
- hazard_stall SHALL stay high until the match clears;
- LD_STALL SHALL stay while hazard_stall is high.

Structure
REQ-022 A shared package SHALL hold:
- the state enum;
- forwarding select constants FWD_REG=2'b00, FWD_ALU=2'b01, FWD_WB=2'b10.
REQ-023 One sub-module, hazard_fwd_match, SHALL compare one source against the EXE/MEM destinations and return the match flags and the select. It SHALL be instantiated three times.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- ADD writing r3 in EXE, ID reads src1=3 -> ALU_vONE_Mux=01 next cycle; no stall.
- LD writing r5 in EXE, ID src2=5, is_imm=0 -> hazard_stall=1 for 1 cycle, selects 00; next ID cycle ALU_vTWO_Mux=10.
- src1=0 with dest_EXE=0, WB_en_EXE=1 -> select 00, no stall.
- br_taken=1 together with load-use -> flush=1, hazard_stall=0, selects 00.
- mem_req=1, mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, selects held, stall_cycles=3, state RUN after mem_ready.
- Without HAZARD_FORWARDING_EN, dest_MEM=7 matches src1=7 -> hazard_stall=1, selects 00.
